io_bus_ctrl: RTL and testbench

Parametrised IO-bus controller between the CPU core's IO port and a set of peripheral channels. It replaces the single-cycle, fixed-width IO port with these features:
- address decode to NUM_CH channels;
- a req/ack wait-state handshake with per-transaction timeout;
- a stall back to the core;
- optional per-channel statistics on a debug read port.

---
 rtl/io_bus_pkg.sv | 18 +
 rtl/io_bus_stats.sv | 64 ++++++
 rtl/io_bus_ctrl.sv | 145 ++++++++++++++
 tb/tb_io_bus_ctrl.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/io_bus_pkg.sv
// Shared types and constants for the IO-bus controller (io_bus_ctrl) and its
// optional statistics block.
package io_bus_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [7:0] DBG_SEL_DECERR = 8'hFF;
    localparam logic [7:0] DBG_SEL_STATUS = 8'hFE;

    // Error read pattern; sliced to DATA_W by users (DATA_W <= 256).
    localparam int MAX_DATA_W = 256;
    localparam logic [MAX_DATA_W-1:0] ERR_DATA = '1;

endpackage

// File: rtl/io_bus_stats.sv
// Per-channel transaction/timeout counters, decode-error counter and the
// registered debug readout mux for io_bus_ctrl (built with IO_BUS_STATS_EN).
module io_bus_stats
    import io_bus_pkg::*;
#(
    parameter int NUM_CH = 4,
    parameter int CH_W   = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  state_t          state,
    input  logic [CH_W-1:0] ch,
    input  logic            err,
    input  logic            dec_err,
    input  logic [7:0]      dbg_sel,
    output logic [31:0]     dbg_data
);

    logic [15:0] txns   [NUM_CH];
    logic [7:0]  touts  [NUM_CH];
    logic [15:0] decerrs;
    logic        err_sticky;
    logic [31:0] dbg_next;
    logic        done;

    assign done = (state == DONE);

    // All counters saturate rather than wrap.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int c = 0; c < NUM_CH; c++) begin
                txns[c]  <= '0;
                touts[c] <= '0;
            end
            decerrs    <= '0;
            err_sticky <= 1'b0;
            dbg_data   <= '0;
        end else begin
            for (int c = 0; c < NUM_CH; c++) begin
                if (done && !dec_err && ch == CH_W'(c)) begin
                    if (!err && txns[c] != 16'hFFFF) txns[c] <= txns[c] + 16'd1;
                    if (err && touts[c] != 8'hFF) touts[c] <= touts[c] + 8'd1;
                end
            end
            if (done && dec_err && decerrs != 16'hFFFF) decerrs <= decerrs + 16'd1;
            if (done && err) err_sticky <= 1'b1;
            dbg_data <= dbg_next;
        end
    end

    always_comb begin
        dbg_next = '0;
        if (dbg_sel == DBG_SEL_DECERR) begin
            dbg_next = {16'b0, decerrs};
        end else if (dbg_sel == DBG_SEL_STATUS) begin
            dbg_next = {28'b0, 1'b0, state, err_sticky};
        end else begin
            for (int c = 0; c < NUM_CH; c++) begin
                if (dbg_sel == 8'(c)) dbg_next = {touts[c], 8'b0, txns[c]};
            end
        end
    end

endmodule

// File: rtl/io_bus_ctrl.sv
// IO-bus controller: decodes CPU IO accesses onto NUM_CH peripheral channels
// with req/ack wait states and timeout. Optional statistics: IO_BUS_STATS_EN.
module io_bus_ctrl
    import io_bus_pkg::*;
#(
    parameter int ADDR_W  = 8,
    parameter int DATA_W  = 32,
    parameter int NUM_CH  = 4,
    parameter int TIMEOUT = 15
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [ADDR_W-1:0]        io_addr,
    input  logic [DATA_W-1:0]        io_dout,
    input  logic                     io_we,
    input  logic                     io_rd,
    output logic [DATA_W-1:0]        io_din,
    output logic                     io_stall,
    output logic                     io_err,
    output logic [NUM_CH-1:0]        per_req,
    output logic                     per_we,
    output logic [ADDR_W-(NUM_CH > 1 ? $clog2(NUM_CH) : 1)-1:0] per_addr,
    output logic [DATA_W-1:0]        per_wdata,
    input  logic [NUM_CH-1:0]        per_ack,
    input  logic [NUM_CH*DATA_W-1:0] per_rdata,
    input  logic [7:0]               dbg_sel,
    output logic [31:0]              dbg_data
);

    localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int OFF_W = ADDR_W - CH_W;
    localparam logic [CH_W:0]     NUM_CH_L = (CH_W + 1)'(NUM_CH);
    localparam logic [7:0]        TO_LAST  = 8'(TIMEOUT - 1);
    localparam logic [DATA_W-1:0] ERR_D    = ERR_DATA[DATA_W-1:0];

    state_t            state;
    logic [CH_W-1:0]   ch_q;
    logic [7:0]        cnt;
    logic              dec_err_q;
    logic              request;
    logic [CH_W-1:0]   ch_in;
    logic              dec_err_in;
    logic [NUM_CH-1:0] onehot_in;
    logic              ack_sel;
    logic [DATA_W-1:0] rdata_sel;

    assign request    = io_we | io_rd;
    assign ch_in      = io_addr[ADDR_W-1 -: CH_W];
    assign dec_err_in = ({1'b0, ch_in} >= NUM_CH_L);
    assign io_stall   = (state == BUSY) || (state == IDLE && request);

    always_comb begin
        onehot_in = '0;
        ack_sel   = 1'b0;
        rdata_sel = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            if (ch_in == CH_W'(c)) onehot_in[c] = 1'b1;
            if (ch_q == CH_W'(c)) begin
                ack_sel   = per_ack[c];
                rdata_sel = per_rdata[c*DATA_W +: DATA_W];
            end
        end
    end

    // Handshake: per_req[ch] is raised on entry to BUSY and held until the
    // cycle after per_ack[ch] is sampled high (or the timeout fires); the
    // peripheral may hold per_ack for any number of cycles, acks from other
    // channels are ignored, and per_* fields are only meaningful while
    // per_req is high.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            ch_q      <= '0;
            cnt       <= '0;
            dec_err_q <= 1'b0;
            io_din    <= '0;
            io_err    <= 1'b0;
            per_req   <= '0;
            per_we    <= 1'b0;
            per_addr  <= '0;
            per_wdata <= '0;
        end else begin
            case (state)
                IDLE: begin
                    io_err <= 1'b0;
                    if (request) begin
                        ch_q      <= ch_in;
                        dec_err_q <= dec_err_in;
                        if (dec_err_in) begin
                            state  <= DONE;
                            io_din <= ERR_D;
                            io_err <= 1'b1;
                        end else begin
                            state     <= BUSY;
                            cnt       <= '0;
                            per_req   <= onehot_in;
                            per_we    <= io_we;
                            per_addr  <= io_addr[OFF_W-1:0];
                            per_wdata <= io_dout;
                        end
                    end
                end
                BUSY: begin
                    if (ack_sel || cnt == TO_LAST) begin
                        state     <= DONE;
                        io_din    <= ack_sel ? (per_we ? '0 : rdata_sel) : ERR_D;
                        io_err    <= !ack_sel;
                        per_req   <= '0;
                        per_we    <= 1'b0;
                        per_addr  <= '0;
                        per_wdata <= '0;
                    end else begin
                        cnt <= cnt + 8'd1;
                    end
                end
                DONE: begin
                    io_err <= 1'b0;
                    state  <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef IO_BUS_STATS_EN
    io_bus_stats #(
        .NUM_CH (NUM_CH),
        .CH_W   (CH_W)
    ) u_stats (
        .clk      (clk),
        .rst      (rst),
        .state    (state),
        .ch       (ch_q),
        .err      (io_err),
        .dec_err  (dec_err_q),
        .dbg_sel  (dbg_sel),
        .dbg_data (dbg_data)
    );
`else
    logic unused_dbg;
    assign unused_dbg = ^{dbg_sel, dec_err_q};
    assign dbg_data   = '0;
`endif

endmodule

// File: tb/tb_io_bus_ctrl.sv
// Directed bench for io_bus_ctrl: a 4-channel instance plus a 3-channel
// instance for the decode-error path; statistics checks follow IO_BUS_STATS_EN.
module tb_io_bus_ctrl;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [7:0]   io_addr = '0;
  logic [31:0]  io_dout = '0;
  logic         io_we = 1'b0;
  logic         io_rd = 1'b0;
  logic [3:0]   per_ack = '0;
  logic [127:0] per_rdata = {32'h3333_3333, 32'h2222_2222, 32'h1234_5678, 32'hAAAA_0000};
  logic [7:0]   dbg_sel = '0;
  logic         sel3 = 1'b0;

  logic         io_we0, io_rd0, io_we3, io_rd3;
  logic [31:0]  io_din, io_din3;
  logic         io_stall, io_stall3, io_err, io_err3;
  logic [3:0]   per_req;
  logic [2:0]   per_req3;
  logic         per_we, per_we3;
  logic [5:0]   per_addr, per_addr3;
  logic [31:0]  per_wdata, per_wdata3;
  logic [31:0]  dbg_data, dbg_data3;

  logic         m_stall, m_err, m_we;
  logic [31:0]  m_din, m_wdata;
  logic [3:0]   m_req;
  logic [5:0]   m_addr;

  int checks = 0;
  int errors = 0;

  assign io_we0 = io_we & ~sel3;
  assign io_rd0 = io_rd & ~sel3;
  assign io_we3 = io_we & sel3;
  assign io_rd3 = io_rd & sel3;

  assign m_stall = sel3 ? io_stall3 : io_stall;
  assign m_err   = sel3 ? io_err3 : io_err;
  assign m_din   = sel3 ? io_din3 : io_din;
  assign m_req   = sel3 ? {1'b0, per_req3} : per_req;
  assign m_we    = sel3 ? per_we3 : per_we;
  assign m_addr  = sel3 ? per_addr3 : per_addr;
  assign m_wdata = sel3 ? per_wdata3 : per_wdata;

  io_bus_ctrl #(.ADDR_W(8), .DATA_W(32), .NUM_CH(4), .TIMEOUT(15)) dut (
    .clk(clk), .rst(rst), .io_addr(io_addr), .io_dout(io_dout),
    .io_we(io_we0), .io_rd(io_rd0), .io_din(io_din), .io_stall(io_stall),
    .io_err(io_err), .per_req(per_req), .per_we(per_we), .per_addr(per_addr),
    .per_wdata(per_wdata), .per_ack(per_ack), .per_rdata(per_rdata),
    .dbg_sel(dbg_sel), .dbg_data(dbg_data)
  );

  io_bus_ctrl #(.ADDR_W(8), .DATA_W(32), .NUM_CH(3), .TIMEOUT(15)) dut3 (
    .clk(clk), .rst(rst), .io_addr(io_addr), .io_dout(io_dout),
    .io_we(io_we3), .io_rd(io_rd3), .io_din(io_din3), .io_stall(io_stall3),
    .io_err(io_err3), .per_req(per_req3), .per_we(per_we3), .per_addr(per_addr3),
    .per_wdata(per_wdata3), .per_ack(per_ack[2:0]), .per_rdata(per_rdata[95:0]),
    .dbg_sel(dbg_sel), .dbg_data(dbg_data3)
  );

  // Clock / reset
  always #5 clk = ~clk;

  // Driver: one transaction starting at the next negedge. ack_at is the BUSY
  // cycle (1-based) that sees ack_val; 0 means never. wrong_ack is driven on
  // all other BUSY cycles. Returns after sampling the first unstalled cycle.
  task automatic do_txn(input logic [7:0] addr, input logic [31:0] wd,
                        input logic we, input logic rd, input int ack_at,
                        input logic [3:0] ack_val, input logic [3:0] wrong_ack,
                        output int stalls, output logic done,
                        output logic [31:0] din, output logic err,
                        output logic [3:0] req_or, output logic we_seen,
                        output logic [5:0] addr_seen, output logic [31:0] wdata_seen);
    stalls = 0; done = 1'b0; din = '0; err = 1'b0; req_or = '0;
    we_seen = 1'b0; addr_seen = '0; wdata_seen = '0;
    @(negedge clk);
    io_addr = addr; io_dout = wd; io_we = we; io_rd = rd;
    for (int i = 0; i < 40 && !done; i++) begin
      if (ack_at > 0 && i == ack_at) per_ack = ack_val;
      else if (i >= 1) per_ack = wrong_ack;
      else per_ack = '0;
      #1;
      if (m_stall) begin
        stalls++;
        req_or |= m_req;
        if (m_req != '0) begin
          we_seen = m_we; addr_seen = m_addr; wdata_seen = m_wdata;
        end
        @(negedge clk);
      end else begin
        done = 1'b1; din = m_din; err = m_err;
      end
    end
    io_we = 1'b0; io_rd = 1'b0; per_ack = '0;
  endtask

  int          st;
  logic        dn, er, wes;
  logic [31:0] dv, wds;
  logic [3:0]  rq;
  logic [5:0]  ads;

  task automatic test_reset();
    repeat (2) @(negedge clk);
    #1;
    checks++; if (io_din !== 32'h0) begin errors++; $display("FAIL reset_io_din got %h exp 0", io_din); end
    checks++; if (io_stall !== 1'b0) begin errors++; $display("FAIL reset_io_stall got %b exp 0", io_stall); end
    checks++; if (io_err !== 1'b0) begin errors++; $display("FAIL reset_io_err got %b exp 0", io_err); end
    checks++; if ({per_req, per_we, per_addr, per_wdata} !== 43'h0) begin errors++; $display("FAIL reset_per got req=%b we=%b addr=%h wdata=%h exp 0", per_req, per_we, per_addr, per_wdata); end
    checks++; if (dbg_data !== 32'h0) begin errors++; $display("FAIL reset_dbg_data got %h exp 0", dbg_data); end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_read();
    do_txn(8'h41, 32'h0, 1'b0, 1'b1, 2, 4'b0010, 4'b0000, st, dn, dv, er, rq, wes, ads, wds);
    checks++; if (dn !== 1'b1) begin errors++; $display("FAIL read_done got %b exp 1", dn); end
    checks++; if (st !== 3) begin errors++; $display("FAIL read_stalls got %0d exp 3", st); end
    checks++; if (dv !== 32'h1234_5678) begin errors++; $display("FAIL read_din got %h exp 12345678", dv); end
    checks++; if (er !== 1'b0) begin errors++; $display("FAIL read_err got %b exp 0", er); end
    checks++; if (rq !== 4'b0010) begin errors++; $display("FAIL read_req got %b exp 0010", rq); end
    checks++; if ({wes, ads} !== {1'b0, 6'h01}) begin errors++; $display("FAIL read_per got we=%b addr=%h exp we=0 addr=01", wes, ads); end
    checks++; if (per_req !== 4'b0) begin errors++; $display("FAIL read_req_in_done got %b exp 0", per_req); end
  endtask

  task automatic test_write();
    do_txn(8'hC5, 32'hCAFE_0001, 1'b1, 1'b0, 1, 4'b1000, 4'b0000, st, dn, dv, er, rq, wes, ads, wds);
    checks++; if (st !== 2 || dn !== 1'b1) begin errors++; $display("FAIL write_stalls got %0d done=%b exp 2 done=1", st, dn); end
    checks++; if (rq !== 4'b1000) begin errors++; $display("FAIL write_req got %b exp 1000", rq); end
    checks++; if ({wes, ads, wds} !== {1'b1, 6'h05, 32'hCAFE_0001}) begin errors++; $display("FAIL write_per got we=%b addr=%h wdata=%h exp we=1 addr=05 wdata=cafe0001", wes, ads, wds); end
    checks++; if (dv !== 32'h0 || er !== 1'b0) begin errors++; $display("FAIL write_done got din=%h err=%b exp din=0 err=0", dv, er); end
  endtask

  task automatic test_timeout();
    do_txn(8'h00, 32'h0, 1'b0, 1'b1, 0, 4'b0000, 4'b0000, st, dn, dv, er, rq, wes, ads, wds);
    checks++; if (st !== 16 || dn !== 1'b1) begin errors++; $display("FAIL timeout_busy_cycles got %0d done=%b exp 15", st - 1, dn); end
    checks++; if (dv !== 32'hFFFF_FFFF) begin errors++; $display("FAIL timeout_din got %h exp ffffffff", dv); end
    checks++; if (er !== 1'b1) begin errors++; $display("FAIL timeout_err got %b exp 1", er); end
    checks++; if (rq !== 4'b0001) begin errors++; $display("FAIL timeout_req got %b exp 0001", rq); end
    @(negedge clk); #1;
    checks++; if (io_err !== 1'b0 || io_din !== 32'hFFFF_FFFF) begin errors++; $display("FAIL timeout_after got err=%b din=%h exp err=0 din=ffffffff", io_err, io_din); end
    dbg_sel = 8'h00;
    @(negedge clk); #1;
`ifdef IO_BUS_STATS_EN
    checks++; if (dbg_data !== 32'h0100_0000) begin errors++; $display("FAIL stats_ch0 got %h exp 01000000", dbg_data); end
    dbg_sel = 8'h03;
    @(negedge clk); #1;
    checks++; if (dbg_data !== 32'h0000_0001) begin errors++; $display("FAIL stats_ch3 got %h exp 00000001", dbg_data); end
    dbg_sel = 8'hFE;
    @(negedge clk); #1;
    checks++; if (dbg_data !== 32'h0000_0001) begin errors++; $display("FAIL stats_status got %h exp 00000001", dbg_data); end
`else
    checks++; if (dbg_data !== 32'h0) begin errors++; $display("FAIL dbg_tied got %h exp 0", dbg_data); end
`endif
    dbg_sel = 8'h00;
  endtask

  task automatic test_wrong_ack();
    do_txn(8'h41, 32'h5555_AAAA, 1'b1, 1'b1, 3, 4'b0110, 4'b0100, st, dn, dv, er, rq, wes, ads, wds);
    checks++; if (st !== 4 || dn !== 1'b1) begin errors++; $display("FAIL wrong_ack_stalls got %0d done=%b exp 4", st, dn); end
    checks++; if (rq !== 4'b0010) begin errors++; $display("FAIL wrong_ack_req got %b exp 0010", rq); end
    checks++; if ({wes, ads, wds} !== {1'b1, 6'h01, 32'h5555_AAAA}) begin errors++; $display("FAIL we_rd_is_write got we=%b addr=%h wdata=%h exp we=1 addr=01 wdata=5555aaaa", wes, ads, wds); end
    checks++; if (dv !== 32'h0 || er !== 1'b0) begin errors++; $display("FAIL wrong_ack_done got din=%h err=%b exp 0 0", dv, er); end
  endtask

  task automatic test_decode_err();
    sel3 = 1'b1;
    do_txn(8'hC0, 32'h0, 1'b0, 1'b1, 0, 4'b0000, 4'b0000, st, dn, dv, er, rq, wes, ads, wds);
    checks++; if (st !== 1 || dn !== 1'b1) begin errors++; $display("FAIL decode_stalls got %0d done=%b exp 1", st, dn); end
    checks++; if (er !== 1'b1 || dv !== 32'hFFFF_FFFF) begin errors++; $display("FAIL decode_done got err=%b din=%h exp err=1 din=ffffffff", er, dv); end
    checks++; if (rq !== 4'b0) begin errors++; $display("FAIL decode_req got %b exp 0", rq); end
    dbg_sel = 8'hFF;
    @(negedge clk); #1;
`ifdef IO_BUS_STATS_EN
    checks++; if (dbg_data3 !== 32'h1) begin errors++; $display("FAIL decode_count got %h exp 00000001", dbg_data3); end
`else
    checks++; if (dbg_data3 !== 32'h0) begin errors++; $display("FAIL decode_dbg_tied got %h exp 0", dbg_data3); end
`endif
    dbg_sel = 8'h00;
    sel3 = 1'b0;
  endtask

  task automatic test_reset_mid_busy();
    @(negedge clk);
    io_addr = 8'h80; io_rd = 1'b1; per_ack = '0;
    repeat (3) @(negedge clk);
    #1;
    checks++; if (per_req !== 4'b0100) begin errors++; $display("FAIL midrst_busy_req got %b exp 0100", per_req); end
    rst = 1'b1; io_rd = 1'b0;
    #1;
    checks++; if (per_req !== 4'b0) begin errors++; $display("FAIL midrst_req_drop got %b exp 0", per_req); end
    checks++; if (io_stall !== 1'b0 || io_err !== 1'b0 || io_din !== 32'h0) begin errors++; $display("FAIL midrst_outputs got stall=%b err=%b din=%h exp 0 0 0", io_stall, io_err, io_din); end
    @(negedge clk); #1;
    checks++; if (io_err !== 1'b0) begin errors++; $display("FAIL midrst_no_done got err=%b exp 0", io_err); end
    rst = 1'b0;
    do_txn(8'h80, 32'h0, 1'b0, 1'b1, 1, 4'b0100, 4'b0000, st, dn, dv, er, rq, wes, ads, wds);
    checks++; if (st !== 2 || dv !== 32'h2222_2222 || er !== 1'b0) begin errors++; $display("FAIL midrst_next got stalls=%0d din=%h err=%b exp 2 22222222 0", st, dv, er); end
  endtask

  task automatic test_back_to_back();
    do_txn(8'hC0, 32'h0, 1'b0, 1'b1, 1, 4'b1000, 4'b0000, st, dn, dv, er, rq, wes, ads, wds);
    checks++; if (st !== 2 || dv !== 32'h3333_3333) begin errors++; $display("FAIL b2b_first got stalls=%0d din=%h exp 2 33333333", st, dv); end
    do_txn(8'h00, 32'h0, 1'b0, 1'b1, 1, 4'b0001, 4'b0000, st, dn, dv, er, rq, wes, ads, wds);
    checks++; if (st !== 2 || dv !== 32'hAAAA_0000 || er !== 1'b0) begin errors++; $display("FAIL b2b_second got stalls=%0d din=%h err=%b exp 2 aaaa0000 0", st, dv, er); end
    @(negedge clk); #1;
    checks++; if (io_din !== 32'hAAAA_0000 || io_stall !== 1'b0) begin errors++; $display("FAIL b2b_hold got din=%h stall=%b exp aaaa0000 0", io_din, io_stall); end
  endtask

  initial begin
    test_reset();
    test_read();
    test_write();
    test_timeout();
    test_wrong_ack();
    test_decode_err();
    test_reset_mid_busy();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
